pipe_stage_reg: RTL and testbench

Parametrised inter-stage pipeline register for the five-stage MIPS datapath. It replaces the per-stage hand-written registers (D→E, E→M, M→W) with one block carrying a packed payload bus, a PC field and a valid bit. It distinguishes hold-on-stall from bubble-on-flush, with a legacy mode that clears on stall. Saturating stall and bubble counters feed the performance-monitor CP0 registers.

---
 rtl/pipe_stage_reg.sv | 93 +++++++++
 tb/tb_pipe_stage_reg.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register: payload, PC and valid, with hold/bubble control
// and saturating stall/bubble event counters for the performance monitor.
module pipe_stage_reg #(
    parameter int              DATA_W        = 160,
    parameter int              PC_W          = 32,
    parameter logic [PC_W-1:0] PC_RST        = PC_W'(32'h0000_3000),
    parameter bit              HOLD_ON_STALL = 1'b1,
    parameter int              CNT_W         = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              flush,
    input  logic              valid_in,
    input  logic [PC_W-1:0]   pc_in,
    input  logic [DATA_W-1:0] data_in,
    output logic              valid_out,
    output logic [PC_W-1:0]   pc_out,
    output logic [DATA_W-1:0] data_out,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  bubble_cnt
);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    // Initialisers make the power-on state match the reset state.
    logic              valid_q      = 1'b0;
    logic [PC_W-1:0]   pc_q         = PC_RST;
    logic [DATA_W-1:0] data_q       = '0;
    logic [CNT_W-1:0]  stall_cnt_q  = '0;
    logic [CNT_W-1:0]  bubble_cnt_q = '0;

    logic              valid_d;
    logic [PC_W-1:0]   pc_d;
    logic [DATA_W-1:0] data_d;
    logic [CNT_W-1:0]  stall_cnt_d;
    logic [CNT_W-1:0]  bubble_cnt_d;

    logic do_bubble;
    logic do_hold;

    // Flush beats stall; in legacy mode a stall degrades into a bubble.
    assign do_bubble = flush | (stall & ~HOLD_ON_STALL);
    assign do_hold   = stall & ~flush & HOLD_ON_STALL;

    always_comb begin
        valid_d      = valid_in;
        pc_d         = pc_in;
        data_d       = data_in;
        stall_cnt_d  = stall_cnt_q;
        bubble_cnt_d = bubble_cnt_q;

        if (do_bubble) begin
            // Bubble keeps the slot PC so EPC/BD tracking still sees it.
            valid_d      = 1'b0;
            data_d       = '0;
            bubble_cnt_d = sat_inc(bubble_cnt_q);
        end else if (do_hold) begin
            valid_d = valid_q;
            pc_d    = pc_q;
            data_d  = data_q;
        end

        if (stall && !flush) begin
            stall_cnt_d = sat_inc(stall_cnt_q);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q      <= 1'b0;
            pc_q         <= PC_RST;
            data_q       <= '0;
            stall_cnt_q  <= '0;
            bubble_cnt_q <= '0;
        end else begin
            valid_q      <= valid_d;
            pc_q         <= pc_d;
            data_q       <= data_d;
            stall_cnt_q  <= stall_cnt_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign valid_out  = valid_q;
    assign pc_out     = pc_q;
    assign data_out   = data_q;
    assign stall_cnt  = stall_cnt_q;
    assign bubble_cnt = bubble_cnt_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: default, legacy-stall and 4-bit-counter
// instances driven by the same stimulus.
module tb_pipe_stage_reg;
    localparam int DW = 160;
    localparam logic [DW-1:0] PAT_A5 = {20{8'hA5}};
    localparam logic [DW-1:0] PAT_3C = {20{8'h3C}};

    logic          clk = 1'b0;
    logic          reset;
    logic          stall;
    logic          flush;
    logic          valid_in;
    logic [31:0]   pc_in;
    logic [DW-1:0] data_in;

    logic          m_valid, l_valid, s_valid;
    logic [31:0]   m_pc, l_pc, s_pc;
    logic [DW-1:0] m_data, l_data, s_data;
    logic [15:0]   m_scnt, m_bcnt, l_scnt, l_bcnt;
    logic [3:0]    s_scnt, s_bcnt;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    pipe_stage_reg u_main (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush),
        .valid_in(valid_in), .pc_in(pc_in), .data_in(data_in),
        .valid_out(m_valid), .pc_out(m_pc), .data_out(m_data),
        .stall_cnt(m_scnt), .bubble_cnt(m_bcnt)
    );

    pipe_stage_reg #(.HOLD_ON_STALL(1'b0)) u_leg (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush),
        .valid_in(valid_in), .pc_in(pc_in), .data_in(data_in),
        .valid_out(l_valid), .pc_out(l_pc), .data_out(l_data),
        .stall_cnt(l_scnt), .bubble_cnt(l_bcnt)
    );

    pipe_stage_reg #(.CNT_W(4)) u_sat (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush),
        .valid_in(valid_in), .pc_in(pc_in), .data_in(data_in),
        .valid_out(s_valid), .pc_out(s_pc), .data_out(s_data),
        .stall_cnt(s_scnt), .bubble_cnt(s_bcnt)
    );

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset    = 1'b1;
        stall    = 1'b0;
        flush    = 1'b0;
        valid_in = 1'b1;
        pc_in    = $urandom;
        data_in  = {$urandom, $urandom, $urandom, $urandom, $urandom};
        tick();
        pc_in    = $urandom;
        data_in  = {$urandom, $urandom, $urandom, $urandom, $urandom};
        tick();
        chk("rst_pc",    DW'(m_pc),    DW'(32'h3000));
        chk("rst_data",  m_data,       '0);
        chk("rst_valid", DW'(m_valid), DW'(1'b0));
        chk("rst_scnt",  DW'(m_scnt),  '0);
        chk("rst_bcnt",  DW'(m_bcnt),  '0);
        chk("rst_l_pc",  DW'(l_pc),    DW'(32'h3000));
        chk("rst_s_scnt", DW'(s_scnt), '0);

        // load
        reset    = 1'b0;
        pc_in    = 32'h3004;
        data_in  = PAT_A5;
        valid_in = 1'b1;
        tick();
        chk("load_pc",    DW'(m_pc),    DW'(32'h3004));
        chk("load_data",  m_data,       PAT_A5);
        chk("load_valid", DW'(m_valid), DW'(1'b1));

        // hold for 3 cycles with changing inputs
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            pc_in    = 32'h4000 + 32'(i * 4);
            data_in  = {$urandom, $urandom, $urandom, $urandom, $urandom};
            valid_in = i[0];
            tick();
            chk("hold_pc",    DW'(m_pc),    DW'(32'h3004));
            chk("hold_data",  m_data,       PAT_A5);
            chk("hold_valid", DW'(m_valid), DW'(1'b1));
            if (i == 0) begin
                chk("leg_scnt1",  DW'(l_scnt),  DW'(16'd1));
                chk("leg_bcnt1",  DW'(l_bcnt),  DW'(16'd1));
                chk("leg_data",   l_data,       '0);
                chk("leg_valid",  DW'(l_valid), DW'(1'b0));
                chk("leg_pc",     DW'(l_pc),    DW'(32'h4000));
            end
        end
        chk("hold_scnt",  DW'(m_scnt), DW'(16'd3));
        chk("hold_bcnt",  DW'(m_bcnt), DW'(16'd0));
        chk("leg_scnt3",  DW'(l_scnt), DW'(16'd3));
        chk("leg_bcnt3",  DW'(l_bcnt), DW'(16'd3));
        chk("leg_pc3",    DW'(l_pc),   DW'(32'h4008));

        // flush alone
        stall    = 1'b0;
        flush    = 1'b1;
        pc_in    = 32'h3010;
        valid_in = 1'b1;
        data_in  = PAT_3C;
        tick();
        chk("fl_valid", DW'(m_valid), DW'(1'b0));
        chk("fl_data",  m_data,       '0);
        chk("fl_pc",    DW'(m_pc),    DW'(32'h3010));
        chk("fl_bcnt",  DW'(m_bcnt),  DW'(16'd1));
        chk("fl_scnt",  DW'(m_scnt),  DW'(16'd3));
        chk("fl_l_bcnt", DW'(l_bcnt), DW'(16'd4));

        // reload
        flush   = 1'b0;
        pc_in   = 32'h3020;
        data_in = DW'(32'h1234_5678);
        tick();
        chk("reload_pc",    DW'(m_pc),    DW'(32'h3020));
        chk("reload_data",  m_data,       DW'(32'h1234_5678));
        chk("reload_valid", DW'(m_valid), DW'(1'b1));

        // flush and stall together
        stall = 1'b1;
        flush = 1'b1;
        pc_in = 32'h3024;
        tick();
        chk("fs_valid",  DW'(m_valid), DW'(1'b0));
        chk("fs_data",   m_data,       '0);
        chk("fs_pc",     DW'(m_pc),    DW'(32'h3024));
        chk("fs_bcnt",   DW'(m_bcnt),  DW'(16'd2));
        chk("fs_scnt",   DW'(m_scnt),  DW'(16'd3));
        chk("fs_l_bcnt", DW'(l_bcnt),  DW'(16'd5));
        chk("fs_l_scnt", DW'(l_scnt),  DW'(16'd3));
        chk("fs_s_scnt", DW'(s_scnt),  DW'(4'd3));

        // long stall: 4-bit counter saturates
        flush = 1'b0;
        for (int i = 0; i < 20; i++) begin
            pc_in   = 32'h5000 + 32'(i);
            data_in = {$urandom, $urandom, $urandom, $urandom, $urandom};
            tick();
            if (i == 11) chk("sat_reach", DW'(s_scnt), DW'(4'd15));
        end
        chk("sat_hold",   DW'(s_scnt), DW'(4'd15));
        chk("sat_bcnt",   DW'(s_bcnt), DW'(4'd2));
        chk("long_scnt",  DW'(m_scnt), DW'(16'd23));
        chk("long_pc",    DW'(m_pc),   DW'(32'h3024));
        chk("long_l_scnt", DW'(l_scnt), DW'(16'd23));
        chk("long_l_bcnt", DW'(l_bcnt), DW'(16'd25));

        // first load after stall
        stall   = 1'b0;
        pc_in   = 32'h3030;
        data_in = PAT_3C;
        tick();
        chk("post_pc",   DW'(m_pc), DW'(32'h3030));
        chk("post_data", m_data,    PAT_3C);

        // reset while stall and flush asserted
        reset = 1'b1;
        stall = 1'b1;
        flush = 1'b1;
        tick();
        chk("mrst_pc",     DW'(m_pc),    DW'(32'h3000));
        chk("mrst_valid",  DW'(m_valid), DW'(1'b0));
        chk("mrst_scnt",   DW'(m_scnt),  '0);
        chk("mrst_bcnt",   DW'(m_bcnt),  '0);
        chk("mrst_s_scnt", DW'(s_scnt),  '0);
        chk("mrst_l_bcnt", DW'(l_bcnt),  '0);

        // load resumes right after reset
        reset   = 1'b0;
        stall   = 1'b0;
        flush   = 1'b0;
        pc_in   = 32'h3040;
        data_in = PAT_A5;
        tick();
        chk("resume_pc",    DW'(m_pc),    DW'(32'h3040));
        chk("resume_data",  m_data,       PAT_A5);
        chk("resume_valid", DW'(m_valid), DW'(1'b1));
        chk("resume_scnt",  DW'(s_scnt),  '0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
